// File: rtl/crc_decoder.sv
// Bit-serial CRC checker: divides a {msg, crc} codeword by the generator
// polynomial one bit per clock and reports message, syndrome and error flag.
module crc_decoder #(
    parameter int MSG_W = 7,
    parameter int GP_W  = 3,
    localparam int CW_W = MSG_W + GP_W - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [GP_W-1:0]    gp,
    input  logic [CW_W-1:0]    cw_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [MSG_W-1:0]   msg_out,
    output logic [GP_W-2:0]    syndrome,
    output logic               crc_err,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         err_cnt,
    output logic [1:0]         fsm_state
);

    localparam int R     = GP_W - 1;
    localparam int CNT_W = $clog2(CW_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CW_W - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; out_valid holds its result until out_ready, in_ready only in IDLE.

    logic [1:0]       state;
    logic [CW_W-1:0]  shreg;
    logic [MSG_W-1:0] msg_r;
    logic [R-1:0]     gp_r;
    logic [R-1:0]     rem;
    logic [R-1:0]     rem_next;
    logic [CNT_W-1:0] cnt;
    logic             top;

    // The generator MSB is implicitly 1, so the input bit carries no information.
    logic gp_msb_unused;
    assign gp_msb_unused = gp[GP_W-1];

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign fsm_state = state;

    always_comb begin
        rem_next    = '0;
        top         = rem[R-1];
        rem_next[0] = shreg[CW_W-1] ^ (top & gp_r[0]);
        for (int i = 1; i < R; i++) begin
            rem_next[i] = rem[i-1] ^ (top & gp_r[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            msg_r    <= '0;
            gp_r     <= '0;
            rem      <= '0;
            cnt      <= '0;
            msg_out  <= '0;
            syndrome <= '0;
            crc_err  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= cw_in;
                        msg_r <= cw_in[CW_W-1:R];
                        gp_r  <= gp[R-1:0];
                        rem   <= '0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    rem   <= rem_next;
                    shreg <= {shreg[CW_W-2:0], 1'b0};
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        msg_out  <= msg_r;
                        syndrome <= rem_next;
                        crc_err  <= |rem_next;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        if (crc_err && (err_cnt != 8'hFF)) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_decoder.sv
// Scoreboard bench for crc_decoder: a long-division reference model feeds an
// expected queue that a monitor drains on every output handshake.
module tb_crc_decoder;

    localparam int MSG_W = 7;
    localparam int GP_W  = 3;
    localparam int R     = GP_W - 1;
    localparam int CW_W  = MSG_W + R;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [GP_W-1:0]  gp;
    logic [CW_W-1:0]  cw_in;
    logic             in_valid;
    logic             in_ready;
    logic [MSG_W-1:0] msg_out;
    logic [R-1:0]     syndrome;
    logic             crc_err;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       err_cnt;
    logic [1:0]       fsm_state;

    crc_decoder #(.MSG_W(MSG_W), .GP_W(GP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gp        (gp),
        .cw_in     (cw_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .msg_out   (msg_out),
        .syndrome  (syndrome),
        .crc_err   (crc_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_cnt   (err_cnt),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;
    int ir_bad = 0;
    int exp_err = 0;
    logic [CW_W:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: polynomial long division of the codeword by {1, gp[R-1:0]}.
    // Result packing: {msg, syndrome, err}.
    function automatic logic [CW_W:0] model(input logic [CW_W-1:0] cw, input logic [GP_W-1:0] g);
        logic [CW_W-1:0] val;
        logic [CW_W-1:0] div;
        logic [R-1:0]    syn;
        val = cw;
        div = CW_W'({1'b1, g[R-1:0]});
        for (int i = CW_W - 1; i >= R; i--) begin
            if (val[i]) val = val ^ (div << (i - R));
        end
        syn = val[R-1:0];
        return {cw[CW_W-1:R], syn, |syn};
    endfunction

    function automatic logic [CW_W-1:0] make_cw(input logic [MSG_W-1:0] msg, input logic [GP_W-1:0] g);
        logic [CW_W:0] r;
        r = model({msg, {R{1'b0}}}, g);
        return {msg, r[R:1]};
    endfunction

    task automatic send(input logic [CW_W-1:0] cw, input logic [GP_W-1:0] g, output int acc_cyc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) check("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        cw_in    = cw;
        gp       = g;
        exp_q.push_back(model(cw, g));
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        cw_in    = CW_W'($urandom);
        gp       = GP_W'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) ir_bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (in_ready !== 1'b0) ir_bad++;
    endtask

    // Monitor: every output handshake pops one expectation.
    always @(negedge clk) begin
        logic [CW_W:0] e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out: got msg %0h syn %0h with nothing expected", msg_out, syndrome);
            end else begin
                e = exp_q.pop_front();
                check("result", 32'({msg_out, syndrome, crc_err}), 32'(e));
                check("err_cnt_pre", 32'(err_cnt), 32'(exp_err));
                if (e[0] && exp_err < 255) exp_err++;
            end
        end
    end

    initial begin
        int a0, a1, lat, hold, bp_bad, pos;
        logic [CW_W:0]    e;
        logic [MSG_W-1:0] m;
        logic [GP_W-1:0]  g;
        logic [CW_W-1:0]  cw;

        rst_n = 1'b0; in_valid = 1'b0; cw_in = '0; gp = '0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_err_cnt",   32'(err_cnt),   32'd0);
        check("rst_outputs",   32'({msg_out, syndrome, crc_err}), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean codeword, latency
        out_ready = 1'b1;
        send(9'b000000111, 3'b111, a0);
        wait_valid(lat);
        check("t1_latency", 32'(lat), 32'(CW_W));
        check("t1_msg", 32'(msg_out), 32'b0000001);
        check("t1_syn", 32'(syndrome), 32'b00);
        check("t1_err", 32'(crc_err), 32'd0);
        @(posedge clk); #1;

        // Back-to-back
        send(9'b000001001, 3'b111, a0);
        wait_valid(lat);
        check("t2a_msg", 32'(msg_out), 32'b0000010);
        check("t2a_syn", 32'(syndrome), 32'b00);
        send(9'b000001110, 3'b111, a1);
        check("t2_period", 32'(a1 - a0), 32'(CW_W + 2));
        wait_valid(lat);
        check("t2b_msg", 32'(msg_out), 32'b0000011);
        check("t2b_syn", 32'(syndrome), 32'b00);
        @(posedge clk); #1;

        // Single-bit error
        check("t3_err_cnt_before", 32'(err_cnt), 32'd0);
        send(9'b000001000, 3'b111, a0);
        wait_valid(lat);
        check("t3_syn", 32'(syndrome), 32'b01);
        check("t3_err", 32'(crc_err), 32'd1);
        check("t3_msg", 32'(msg_out), 32'b0000010);
        @(posedge clk); #1;
        check("t3_err_cnt_after", 32'(err_cnt), 32'd1);

        // Backpressure for 20 clocks with junk on the input side
        out_ready = 1'b0;
        send(9'b000000110, 3'b111, a0);
        e = model(9'b000000110, 3'b111);
        wait_valid(lat);
        bp_bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom);
            cw_in    = CW_W'($urandom);
            gp       = GP_W'($urandom);
            if (out_valid !== 1'b1 || {msg_out, syndrome, crc_err} !== e || err_cnt !== 8'd1)
                bp_bad++;
        end
        in_valid = 1'b0;
        check("t4_stable", 32'(bp_bad), 32'd0);
        check("t4_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_err_cnt", 32'(err_cnt), 32'd2);
        check("t4_out_valid_low", 32'(out_valid), 32'd0);
        check("t4_in_ready_high", 32'(in_ready), 32'd1);

        // Asynchronous reset at bit 4 of SHIFT
        send(9'b000001001, 3'b111, a0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        exp_err = 0;
        #1;
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd1);
        check("t5_err_cnt", 32'(err_cnt), 32'd0);
        check("t5_outputs", 32'({msg_out, syndrome, crc_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(9'b000001110, 3'b111, a0);
        wait_valid(lat);
        check("t5_latency", 32'(lat), 32'(CW_W));
        check("t5_msg", 32'(msg_out), 32'b0000011);
        @(posedge clk); #1;

        // Random mix of clean and corrupted codewords, random polynomials and stalls
        for (int n = 0; n < 40; n++) begin
            m  = MSG_W'($urandom);
            g  = GP_W'($urandom);
            cw = ($urandom_range(0, 1) == 1) ? make_cw(m, g) : CW_W'($urandom);
            hold = $urandom_range(0, 3);
            out_ready = (hold == 0);
            send(cw, g, a0);
            wait_valid(lat);
            check("rand_latency", 32'(lat), 32'(CW_W));
            repeat (hold) begin
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
        end

        // Saturation: 300 single-bit errors
        out_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            m   = MSG_W'($urandom);
            g   = {1'($urandom), {R{1'b1}}};
            pos = $urandom_range(0, CW_W - 1);
            cw  = make_cw(m, g) ^ (CW_W'(1) << pos);
            send(cw, g, a0);
            wait_valid(lat);
            @(posedge clk); #1;
        end
        check("sat_err_cnt", 32'(err_cnt), 32'd255);

        repeat (3) @(posedge clk);
        #1;
        check("in_ready_busy", 32'(ir_bad), 32'd0);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
